run_ctrl: RTL
=============

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 12, meaning the core program-counter width.
REQ-002 The block SHALL have parameter HALT_PC, default 128, meaning the PC value that signals program completion.
REQ-003 The block SHALL have parameter RST_CYCLES, default 2, range 1..15, meaning the number of cycles core_reset is held after a start.
REQ-004 The block SHALL have parameter CYC_WIDTH, default 16, meaning the cycle_count width.
REQ-005 The block SHALL have parameter TIMEOUT, default 65535, range 1..2^CYC_WIDTH-1, meaning the maximum number of RUN cycles before forced stop.
REQ-006 The block SHALL have port clk  input  1  the single system clock; all state changes on rising edge.
REQ-007 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 The block SHALL have port req  input  1  start request; only its rising edge acts.
REQ-009 The block SHALL have port prog_ctr  input  PC_WIDTH  the current core program counter.
REQ-010 The block SHALL have port core_reset  output  1  the reset applied to the core (PC and flag registers).
REQ-011 The block SHALL have port core_en  output  1  the core advance enable (PC update, RegWrite, MemWrite gating).
REQ-012 The block SHALL have port busy  output  1  high in the RESET and RUN states.
REQ-013 The block SHALL have port done  output  1  high in the DONE state.
REQ-014 The block SHALL have port timeout  output  1  high in DONE when the stop was forced by TIMEOUT.
REQ-015 The block SHALL have port cycle_count  output  CYC_WIDTH  the number of RUN cycles in the current or last run.

Function
REQ-016 The FSM SHALL have the states IDLE, RESET, RUN and DONE; all outputs SHALL be decoded from registered state and counters (Moore), with no combinational path from any input to any output.
REQ-017 A start event SHALL be defined as req=1 at a clock edge while the registered previous req (req_q) is 0.
REQ-018 In IDLE: core_reset=1, core_en=0; a start event SHALL move the FSM to RESET, load the reset counter with RST_CYCLES-1, and clear cycle_count, done and timeout.
REQ-019 In RESET: core_reset=1, core_en=0; the counter SHALL decrement each edge and the FSM SHALL move to RUN on the edge where the counter is 0, so core_reset is high for exactly RST_CYCLES cycles after the start edge.
REQ-020 In RUN: core_reset=0, core_en=1; cycle_count SHALL increment by 1 on every edge spent in RUN, including the exit edge.
REQ-021 In RUN, prog_ctr==HALT_PC at an edge SHALL move the FSM to DONE with timeout=0.
REQ-022 In RUN, cycle_count==TIMEOUT-1 at an edge SHALL move the FSM to DONE with timeout=1; halt SHALL take priority when both occur on the same edge.
REQ-023 In DONE: core_reset=0, core_en=0 (core state frozen for inspection); done, timeout and cycle_count SHALL hold until the next start event.
REQ-024 A start event in DONE SHALL act as in IDLE (go to RESET, clear done, timeout and cycle_count).
REQ-025 Start events in RESET or RUN SHALL be ignored; a req level held high SHALL NOT retrigger.
REQ-026 cycle_count SHALL never wrap, bounded by REQ-022 and REQ-005.

Reset
REQ-027 Asserting reset at any time, including mid-run, SHALL asynchronously force state=IDLE, req_q=0, reset counter=0, cycle_count=0, done=0, timeout=0, busy=0, core_reset=1 and core_en=0.
REQ-028 After reset deasserts, a req already high SHALL count as a start event on the first edge.

Structure
REQ-029 The run_state_t enum (IDLE, RESET, RUN, DONE) and default parameter constants SHALL reside in shared package run_pkg.
REQ-030 The saturating, clearable RUN-cycle counter SHALL be a single sub-module named cyc_counter; all other logic SHALL be in run_ctrl.

Verification
REQ-031 The bench PC model SHALL start at 0 on core_reset and increment when core_en=1, and SHALL be used for all the following scenarios.
REQ-032 Scenario: reset then idle, req=0 for 10 cycles -> core_reset=1, core_en=0, done=0, cycle_count=0 throughout.
REQ-033 Scenario: defaults, single req pulse -> core_reset high for exactly 2 cycles, then core_en=1; done=1, timeout=0 and cycle_count=129 once PC reaches 128.
REQ-034 Scenario: TIMEOUT=50, HALT_PC=4095 -> done=1, timeout=1, cycle_count=50, core_en=0 thereafter.
REQ-035 Scenario: req held high through the run, then a second rising edge in DONE -> no retrigger while held; the second edge clears done and cycle_count and repeats the run, again ending at 129.
REQ-036 Scenario: reset asserted at RUN cycle 40 -> same cycle: core_reset=1, core_en=0, busy=0, cycle_count=0; no done.
REQ-037 Scenario: TIMEOUT=129 with halt at RUN cycle 129 -> done=1, timeout=0 (halt priority).

Source files
------------

// File: rtl/run_pkg.sv
// Shared types and default constants for the run controller.
package run_pkg;

    // Controller states: core held in reset, core running, core frozen after stop.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_t;

    // Default parameter values for run_ctrl.
    localparam int unsigned DEF_PC_WIDTH   = 12;
    localparam int unsigned DEF_HALT_PC    = 128;
    localparam int unsigned DEF_RST_CYCLES = 2;
    localparam int unsigned DEF_CYC_WIDTH  = 16;
    localparam int unsigned DEF_TIMEOUT    = 65535;

    // Width of the core-reset hold counter (RST_CYCLES is at most 15).
    localparam int unsigned RST_CNT_WIDTH  = 4;

endpackage

// File: rtl/cyc_counter.sv
// Saturating, synchronously clearable counter of RUN cycles.
module cyc_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Clear has priority over increment; the count sticks at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences core reset, run and stop (halt or timeout) on a
// rising edge of req. All outputs are decoded from registered state only.
module run_ctrl
    import run_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = DEF_PC_WIDTH,
    parameter int unsigned HALT_PC    = DEF_HALT_PC,
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
    parameter int unsigned CYC_WIDTH  = DEF_CYC_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic [PC_WIDTH-1:0]  prog_ctr,
    output logic                 core_reset,
    output logic                 core_en,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CYC_WIDTH-1:0] cycle_count
);

    localparam logic [RST_CNT_WIDTH-1:0] RST_LOAD  = RST_CNT_WIDTH'(RST_CYCLES - 1);
    localparam logic [PC_WIDTH-1:0]      HALT_VAL  = PC_WIDTH'(HALT_PC);
    localparam logic [CYC_WIDTH-1:0]     LAST_CYC  = CYC_WIDTH'(TIMEOUT - 1);

    run_state_t               r_state;
    run_state_t               w_state_nxt;
    logic                     r_req_q;
    logic [RST_CNT_WIDTH-1:0] r_rst_cnt;
    logic [RST_CNT_WIDTH-1:0] w_rst_cnt_nxt;
    logic                     r_timeout;
    logic                     w_timeout_nxt;
    logic                     w_start;
    logic                     w_halt;
    logic                     w_limit;
    logic                     w_cnt_clr;
    logic                     w_cnt_inc;
    logic [CYC_WIDTH-1:0]     w_count;

    assign w_start = req & ~r_req_q;
    assign w_halt  = (prog_ctr == HALT_VAL);
    assign w_limit = (w_count == LAST_CYC);

    // State, reset-hold counter, timeout flag and req history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_req_q   <= 1'b0;
            r_rst_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_q   <= req;
            r_rst_cnt <= w_rst_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state and counter control; halt wins over timeout on the same edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_timeout_nxt = r_timeout;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (w_start) begin
                    w_state_nxt   = RESET;
                    w_rst_cnt_nxt = RST_LOAD;
                    w_timeout_nxt = 1'b0;
                    w_cnt_clr     = 1'b1;
                end
            end
            RESET: begin
                if (r_rst_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt - 1'b1;
                end
            end
            RUN: begin
                w_cnt_inc = 1'b1;
                if (w_halt) begin
                    w_state_nxt   = DONE;
                    w_timeout_nxt = 1'b0;
                end else if (w_limit) begin
                    w_state_nxt   = DONE;
                    w_timeout_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        core_reset = 1'b0;
        core_en    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (r_state)
            IDLE:    core_reset = 1'b1;
            RESET: begin
                core_reset = 1'b1;
                busy       = 1'b1;
            end
            RUN: begin
                core_en = 1'b1;
                busy    = 1'b1;
            end
            DONE:    done = 1'b1;
            default: core_reset = 1'b1;
        endcase
    end

    assign timeout     = r_timeout;
    assign cycle_count = w_count;

    cyc_counter #(
        .WIDTH (CYC_WIDTH)
    ) u_cyc_counter (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_count (w_count)
    );

endmodule
